// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
//   XLEN_DEF / NREGS_DEF / NRD_DEF / NWR_DEF : default parameter values
//   aw_of()                                  : address width for a register count
//   *_W_DEF                                  : flattened port-vector widths at defaults
package regfile_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;
    localparam int unsigned NRD_DEF   = 2;
    localparam int unsigned NWR_DEF   = 2;

    // Register count is a power of two >= 2, so this is exact.
    function automatic int unsigned aw_of(input int unsigned nregs);
        return $clog2(nregs);
    endfunction

    localparam int unsigned AW_DEF      = aw_of(NREGS_DEF);
    localparam int unsigned WADDR_W_DEF = NWR_DEF * AW_DEF;
    localparam int unsigned WDATA_W_DEF = NWR_DEF * XLEN_DEF;
    localparam int unsigned RADDR_W_DEF = NRD_DEF * AW_DEF;
    localparam int unsigned RDATA_W_DEF = NRD_DEF * XLEN_DEF;

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits for the register file.
//   CLK, RST_N          : clock (rising edge), async active-low reset
//   WE, WADDR           : write ports; a write clears the target's pending bit
//   RADDR -> RVALID     : per read port, 1 when the addressed register is not pending
//   RSV_EN, RSV_ADDR    : reserve a destination register at issue
//   RSV_STALL           : reservation refused because the target is already pending
//   FLUSH               : clear every pending bit, beating same-cycle reservations
//   PEND_CNT            : registered popcount of the pending bits
// Register 0 is never pending.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned NWR   = NWR_DEF
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NWR-1:0]                 WE,
    input  logic [NWR*aw_of(NREGS)-1:0]    WADDR,
    input  logic [NRD*aw_of(NREGS)-1:0]    RADDR,
    output logic [NRD-1:0]                 RVALID,
    input  logic                           RSV_EN,
    input  logic [aw_of(NREGS)-1:0]        RSV_ADDR,
    output logic                           RSV_STALL,
    input  logic                           FLUSH,
    output logic [aw_of(NREGS):0]          PEND_CNT
);

    localparam int unsigned AW = aw_of(NREGS);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_nxt;
    logic [AW:0]      cnt_nxt;

    assign RSV_STALL = RSV_EN && (RSV_ADDR != '0) && pend_q[RSV_ADDR];

    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            RVALID[j] = !pend_q[RADDR[j*AW +: AW]];
        end
    end

    // Priority, lowest to highest: write clears, reservation sets, flush clears all.
    // Ordering the set after the clears makes a same-cycle reserve+write end pending.
    always_comb begin
        pend_nxt = pend_q;
        for (int unsigned k = 0; k < NWR; k++) begin
            if (WE[k] && (WADDR[k*AW +: AW] != '0)) begin
                pend_nxt[WADDR[k*AW +: AW]] = 1'b0;
            end
        end
        if (RSV_EN && !RSV_STALL && (RSV_ADDR != '0)) begin
            pend_nxt[RSV_ADDR] = 1'b1;
        end
        if (FLUSH) begin
            pend_nxt = '0;
        end
        pend_nxt[0] = 1'b0;
    end

    // Count recomputed from the next-state vector so simultaneous sets and
    // clears can never drift the counter away from the real popcount.
    always_comb begin
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            cnt_nxt = cnt_nxt + {{AW{1'b0}}, pend_nxt[i]};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pend_q   <= '0;
            PEND_CNT <= '0;
        end else begin
            pend_q   <= pend_nxt;
            PEND_CNT <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a pending-bit scoreboard.
//   CLK, RST_N          : clock (rising edge), async active-low reset
//   WE/WADDR/WDATA      : NWR write ports, port k at slice k; highest port wins a collision
//   RADDR/RDATA         : NRD combinational read ports; register 0 reads as zero
//   RVALID              : per read port, addressed register not pending
//   RSV_EN/RSV_ADDR     : reserve a destination; RSV_STALL reports a refusal
//   FLUSH               : clear all pending bits (data untouched)
//   PEND_CNT            : registered number of pending registers
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = NRD_DEF,
    parameter int unsigned NWR   = NWR_DEF
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NWR-1:0]                 WE,
    input  logic [NWR*aw_of(NREGS)-1:0]    WADDR,
    input  logic [NWR*XLEN-1:0]            WDATA,
    input  logic [NRD*aw_of(NREGS)-1:0]    RADDR,
    output logic [NRD*XLEN-1:0]            RDATA,
    output logic [NRD-1:0]                 RVALID,
    input  logic                           RSV_EN,
    input  logic [aw_of(NREGS)-1:0]        RSV_ADDR,
    output logic                           RSV_STALL,
    input  logic                           FLUSH,
    output logic [aw_of(NREGS):0]          PEND_CNT
);

    localparam int unsigned AW = aw_of(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    logic [NRD-1:0]  sb_rvalid;

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) u_scoreboard (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WE        (WE),
        .WADDR     (WADDR),
        .RADDR     (RADDR),
        .RVALID    (sb_rvalid),
        .RSV_EN    (RSV_EN),
        .RSV_ADDR  (RSV_ADDR),
        .RSV_STALL (RSV_STALL),
        .FLUSH     (FLUSH),
        .PEND_CNT  (PEND_CNT)
    );

    // Later ports overwrite earlier ones in the loop, so the highest index wins.
    // Register 0 is never written and therefore stays zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NWR; k++) begin
                if (WE[k] && (WADDR[k*AW +: AW] != '0)) begin
                    regs[WADDR[k*AW +: AW]] <= WDATA[k*XLEN +: XLEN];
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic [NRD-1:0] byp_hit;

    // Forwarding is gated by RST_N so reads stay zero while reset is held.
    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            byp_hit[j]             = 1'b0;
            RDATA[j*XLEN +: XLEN]  = regs[RADDR[j*AW +: AW]];
            for (int unsigned k = 0; k < NWR; k++) begin
                if (RST_N && WE[k] && (WADDR[k*AW +: AW] != '0) &&
                    (WADDR[k*AW +: AW] == RADDR[j*AW +: AW])) begin
                    byp_hit[j]            = 1'b1;
                    RDATA[j*XLEN +: XLEN] = WDATA[k*XLEN +: XLEN];
                end
            end
        end
    end

    assign RVALID = sb_rvalid | byp_hit;
`else
    always_comb begin
        for (int unsigned j = 0; j < NRD; j++) begin
            RDATA[j*XLEN +: XLEN] = regs[RADDR[j*AW +: AW]];
        end
    end

    assign RVALID = sb_rvalid;
`endif

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    logic        CLK;
    logic        RST_N;
    logic [1:0]  WE;
    logic [9:0]  WADDR;
    logic [63:0] WDATA;
    logic [9:0]  RADDR;
    logic [63:0] RDATA;
    logic [1:0]  RVALID;
    logic        RSV_EN;
    logic [4:0]  RSV_ADDR;
    logic        RSV_STALL;
    logic        FLUSH;
    logic [5:0]  PEND_CNT;

    int errors = 0;
    int checks = 0;

    regfile_mp #(
        .XLEN  (32),
        .NREGS (32),
        .NRD   (2),
        .NWR   (2)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .RADDR     (RADDR),
        .RDATA     (RDATA),
        .RVALID    (RVALID),
        .RSV_EN    (RSV_EN),
        .RSV_ADDR  (RSV_ADDR),
        .RSV_STALL (RSV_STALL),
        .FLUSH     (FLUSH),
        .PEND_CNT  (PEND_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        WE = '0; WADDR = '0; WDATA = '0;
        RSV_EN = 1'b0; RSV_ADDR = '0; FLUSH = 1'b0;
    endtask

    initial begin
        RST_N = 1'b0;
        RADDR = '0;
        idle();
        #1;
        chk("rst_init_pend", 64'(PEND_CNT), 64'd0);
        chk("rst_init_rvalid", 64'(RVALID), 64'd3);
        #1;
        RST_N = 1'b1;
        tick();

        // Two independent writes on the two ports.
        WE = 2'b11; WADDR = {5'd2, 5'd1}; WDATA = {32'h20, 32'h10};
        tick();
        idle();
        RADDR = {5'd2, 5'd1};
        #1;
        chk("wr_two_ports", RDATA, {32'h20, 32'h10});

        // Same-address collision: port 1 must win.
        WE = 2'b11; WADDR = {5'd5, 5'd5}; WDATA = {32'h2222, 32'h1111};
        tick();
        idle();
        RADDR = {5'd1, 5'd5};
        #1;
        chk("collision_hi_wins", RDATA, {32'h10, 32'h2222});

        // Writes to x0 are discarded.
        WE = 2'b01; WADDR = {5'd0, 5'd0}; WDATA = {32'h0, 32'hDEADBEEF};
        tick();
        idle();
        RADDR = {5'd0, 5'd0};
        #1;
        chk("x0_data", RDATA, 64'd0);
        chk("x0_valid", 64'(RVALID), 64'd3);
        RSV_EN = 1'b1; RSV_ADDR = 5'd0;
        #1;
        chk("x0_rsv_stall", 64'(RSV_STALL), 64'd0);
        tick();
        idle();
        chk("x0_rsv_pend", 64'(PEND_CNT), 64'd0);

        // Reserve x7, then try again while pending.
        RSV_EN = 1'b1; RSV_ADDR = 5'd7;
        #1;
        chk("rsv7_stall_first", 64'(RSV_STALL), 64'd0);
        tick();
        idle();
        RADDR = {5'd0, 5'd7};
        #1;
        chk("rsv7_pend", 64'(PEND_CNT), 64'd1);
        chk("rsv7_rvalid", 64'(RVALID), 64'd2);
        RSV_EN = 1'b1; RSV_ADDR = 5'd7;
        #1;
        chk("rsv7_again_stall", 64'(RSV_STALL), 64'd1);
        tick();
        idle();
        chk("rsv7_again_pend", 64'(PEND_CNT), 64'd1);

        // Write x7 (clears) and reserve x9 (sets) in one cycle.
        WE = 2'b01; WADDR = {5'd0, 5'd7}; WDATA = {32'h0, 32'hA5};
        RSV_EN = 1'b1; RSV_ADDR = 5'd9;
        tick();
        idle();
        RADDR = {5'd9, 5'd7};
        #1;
        chk("swap_pend", 64'(PEND_CNT), 64'd1);
        chk("swap_rvalid", 64'(RVALID), 64'd1);
        chk("swap_x7_data", 64'(RDATA[31:0]), 64'hA5);

        // Reserve and write x3 together while x3 is free: ends pending with new data.
        WE = 2'b10; WADDR = {5'd3, 5'd0}; WDATA = {32'h42, 32'h0};
        RSV_EN = 1'b1; RSV_ADDR = 5'd3;
        tick();
        idle();
        RADDR = {5'd9, 5'd3};
        #1;
        chk("rsvwr_pend", 64'(PEND_CNT), 64'd2);
        chk("rsvwr_rvalid", 64'(RVALID), 64'd0);
        chk("rsvwr_data", 64'(RDATA[31:0]), 64'h42);

        // Flush beats a same-cycle reservation; data survives.
        FLUSH = 1'b1; RSV_EN = 1'b1; RSV_ADDR = 5'd12;
        tick();
        idle();
        RADDR = {5'd12, 5'd3};
        #1;
        chk("flush_pend", 64'(PEND_CNT), 64'd0);
        chk("flush_rvalid", 64'(RVALID), 64'd3);
        chk("flush_data", 64'(RDATA[31:0]), 64'h42);

        // Same-cycle read of x4 while it is written.
        RADDR = {5'd0, 5'd4};
        WE = 2'b01; WADDR = {5'd0, 5'd4}; WDATA = {32'h0, 32'h55};
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("bypass_same_cycle", 64'(RDATA[31:0]), 64'h55);
`else
        chk("bypass_same_cycle", 64'(RDATA[31:0]), 64'h0);
`endif
        chk("bypass_same_valid", 64'(RVALID[0]), 64'd1);
        tick();
        idle();
        #1;
        chk("bypass_next_cycle", 64'(RDATA[31:0]), 64'h55);

        // Build up pending state, then reset asynchronously mid-cycle.
        RSV_EN = 1'b1; RSV_ADDR = 5'd10;
        tick();
        RSV_ADDR = 5'd11;
        tick();
        idle();
        chk("pend_two", 64'(PEND_CNT), 64'd2);
        WE = 2'b11; WADDR = {5'd6, 5'd5}; WDATA = {32'h66, 32'h77};
        RSV_EN = 1'b1; RSV_ADDR = 5'd10;
        RADDR = {5'd7, 5'd5};
        #2;
        RST_N = 1'b0;
        #1;
        chk("midrst_rdata", RDATA, 64'd0);
        chk("midrst_pend", 64'(PEND_CNT), 64'd0);
        chk("midrst_rvalid", 64'(RVALID), 64'd3);
        chk("midrst_stall", 64'(RSV_STALL), 64'd0);
        @(negedge CLK);
        idle();
        RST_N = 1'b1;
        RADDR = {5'd6, 5'd5};
        #1;
        chk("postrst_rdata", RDATA, 64'd0);
        tick();
        chk("postrst_pend", 64'(PEND_CNT), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning data word width in bits.
REQ-002 The block SHALL have parameter NREGS, default 32, meaning register count (power of two, >= 2); AW = log2(NREGS).
REQ-003 The block SHALL have parameter NRD, default 2, meaning read port count.
REQ-004 The block SHALL have parameter NWR, default 2, meaning write port count.
REQ-005 Ports SHALL be:
- CLK  in  1  clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- WE  in  NWR  per-port write enable
- WADDR  in  NWR*AW  write addresses, port k at bits [k*AW +: AW]
- WDATA  in  NWR*XLEN  write data, port k at bits [k*XLEN +: XLEN]
- RADDR  in  NRD*AW  read addresses
- RDATA  out  NRD*XLEN  read data, combinational
- RVALID  out  NRD  read register not pending
- RSV_EN  in  1  reserve destination at issue
- RSV_ADDR  in  AW  register to reserve
- RSV_STALL  out  1  reservation refused
- FLUSH  in  1  clear all pending bits
- PEND_CNT  out  AW+1  number of pending registers

Function
REQ-006 The block SHALL hold NREGS XLEN-bit registers plus one pending bit per register.
REQ-007 Register 0 SHALL read as 0 with RVALID=1, ignore writes, never become pending and never stall.
REQ-008 Each write with WE[k]=1 and WADDR!=0 SHALL update the register on the rising CLK edge and clear its pending bit.
REQ-009 If several write ports target the same address in one cycle, the highest-index port SHALL win.
REQ-010 RDATA[j] SHALL equal the register contents; RVALID[j] SHALL equal !pending[RADDR[j]].
REQ-011 RSV_STALL SHALL equal RSV_EN && RSV_ADDR!=0 && pending[RSV_ADDR], combinationally.
REQ-012 A reservation with RSV_EN=1 and RSV_STALL=0 SHALL set pending[RSV_ADDR] on the next edge.
REQ-013 If a reservation and a write hit the same non-pending address in one cycle, the reservation SHALL win and the bit ends set.
REQ-014 FLUSH=1 SHALL clear all pending bits on the next edge, overriding same-cycle reservations; register data is unaffected.
REQ-015 PEND_CNT SHALL be a registered count equal to the popcount of pending bits after every edge. It SHALL track set/clear events in the same cycle exactly and SHALL never wrap, because its maximum is NREGS-1.
REQ-016 A write to a non-pending register SHALL be legal and SHALL only update data.

Reset
REQ-017 RST_N low SHALL immediately zero all registers, all pending bits and PEND_CNT, independent of CLK.
REQ-018 While RST_N is low, outputs SHALL be RDATA=0, RVALID all 1, RSV_STALL=0 and PEND_CNT=0. A reset mid-operation SHALL discard any write or reservation in that cycle.

Configuration
REQ-019 Macro REGFILE_BYPASS_EN defined: a read port whose RADDR matches an active same-cycle write (WE=1, address !=0) SHALL return that WDATA, using the highest-index port, with RVALID=1.
REQ-020 Macro REGFILE_BYPASS_EN undefined: reads SHALL return the pre-edge value; new data and RVALID=1 SHALL appear the cycle after the write edge.

Structure
REQ-021 The shared package regfile_pkg SHALL hold the default XLEN/NREGS constants, the AW derivation function and the port-slice helper localparams.
REQ-022 Pending bits, the reservation/stall logic, FLUSH and PEND_CNT SHALL live in the sub-module regfile_scoreboard; regfile_mp instantiates it alongside the data array.

Verification
REQ-023 The bench SHALL cover these directed scenarios (defaults unless stated):
- Reset: pulse RST_N low mid-run -> all RDATA=0, PEND_CNT=0, RVALID=2'b11 while low.
- Dual write collision: WE=2'b11, both WADDR=5, WDATA 0x1111/0x2222 -> next cycle RADDR=5 gives 0x2222.
- x0 write: WE[0]=1, WADDR=0, WDATA=0xDEADBEEF -> RDATA for x0 stays 0 and RVALID=1. Then RSV_EN with RSV_ADDR=0 -> RSV_STALL=0 and PEND_CNT stays 0.
- Scoreboard: reserve x7 -> PEND_CNT=1 and RVALID for x7 =0. Reserve x7 again -> RSV_STALL=1. Write x7=0xA5 and reserve x9 in the same cycle -> PEND_CNT=1, x7 valid, x9 pending.
- Reserve+write same address: reserve x3 and write x3=0x42 with x3 not pending -> x3 pending, data 0x42. Then FLUSH -> PEND_CNT=0.
- Bypass: write x4=0x55 while RADDR=4 -> same cycle RDATA=0x55 with REGFILE_BYPASS_EN, old value without it; 0x55 next cycle in both cases.
